// File: rtl/ifetch_pkg.sv
// Shared encodings for the fetch unit: decoder PC_INC/PC_JUMP fields and instruction field widths.
// No logic; constants and a sign-extension helper only.
package ifetch_pkg;

    localparam logic [1:0] PC_INC_NORMAL = 2'd0;
    localparam logic [1:0] PC_INC_BRANCH = 2'd1;
    localparam logic [1:0] PC_INC_JUMP   = 2'd2;
    localparam logic [1:0] PC_INC_STOP   = 2'd3;

    localparam logic PC_JUMP_IMME = 1'b0;
    localparam logic PC_JUMP_REG  = 1'b1;

    localparam int INS_RAW_IMME = 16;
    localparam int INS_RAW_ADDR = 26;

    function automatic logic [31:0] sext_imme(input logic [INS_RAW_IMME-1:0] imm);
        return {{(32-INS_RAW_IMME){imm[INS_RAW_IMME-1]}}, imm};
    endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Next-PC selection from decoded PC_INC/PC_JUMP fields, plus JR misalignment and stop detection.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Only used by the parent when the held instruction is acked.
module ifetch_npc import ifetch_pkg::*; (
    input  logic [31:0]             pc,
    input  logic [31:0]             pc_plus4,
    input  logic [INS_RAW_ADDR-1:0] ins_field,
    input  logic [1:0]              pc_inc,
    input  logic                    pc_jump,
    input  logic                    branch_taken,
    input  logic [31:0]             jr_target,
    output logic [31:0]             next_pc,
    output logic                    stop,
    output logic                    misalign
);

    always_comb begin
        next_pc  = pc_plus4;
        stop     = 1'b0;
        misalign = 1'b0;
        case (pc_inc)
            PC_INC_BRANCH: begin
                if (branch_taken)
                    next_pc = pc_plus4 + (sext_imme(ins_field[INS_RAW_IMME-1:0]) << 2);
            end
            PC_INC_JUMP: begin
                if (pc_jump == PC_JUMP_REG) begin
                    next_pc  = jr_target;
                    misalign = |jr_target[1:0];
                end else begin
                    next_pc = {pc_plus4[31:28], ins_field, 2'b00};
                end
            end
            PC_INC_STOP: begin
                next_pc = pc;
                stop    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, holds the word for decode, forms next PC on ack.
// Latency: 3 cycles per instruction with zero-wait memory and ack held high (1 extra after reset).
// Backpressure: request held until imem_req_ready; instruction held until ins_ack; HALT is sticky.
module ifetch import ifetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ack,
    input  logic [1:0]  pc_inc,
    input  logic        pc_jump,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fetch_err,
    output logic [31:0] retired
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic        npc_stop;
    logic        npc_misalign;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    ifetch_npc u_npc (
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .ins_field    (ins[INS_RAW_ADDR-1:0]),
        .pc_inc       (pc_inc),
        .pc_jump      (pc_jump),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .stop         (npc_stop),
        .misalign     (npc_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            ins            <= 32'd0;
            imem_req_valid <= 1'b0;
            ins_valid      <= 1'b0;
            halted         <= 1'b0;
            fetch_err      <= 1'b0;
            retired        <= 32'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // req_valid resets low, so the first request after reset rises one cycle late
                    if (!imem_req_valid) begin
                        imem_req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        ins       <= imem_rsp_data;
                        ins_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ins_ack) begin
                        retired   <= retired + 32'd1;
                        ins_valid <= 1'b0;
                        if (npc_misalign) begin
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            state     <= ST_HALT;
                        end else if (npc_stop) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc             <= next_pc;
                            imem_req_valid <= 1'b1;
                            state          <= ST_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
